// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic pipeline stage: the upstream beat and
// accept signal, plus the downstream beat and its back-pressure.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // Environment side: produces upstream beats and consumes downstream ones.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Generic pipeline-boundary register with valid/ready back-pressure, a 2-entry
// skid buffer, control-killing flush and a saturating flushed-beat counter.
module pipe_stage_elastic #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 Flush,
  pipe_stage_elastic_if.slave  bus,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic              m_valid_r, m_valid_s;
  logic [DATA_W-1:0] m_data_r,  m_data_s;
  logic [CTRL_W-1:0] m_ctrl_r,  m_ctrl_s;
  logic              s_valid_r, s_valid_s;
  logic [DATA_W-1:0] s_data_r,  s_data_s;
  logic [CTRL_W-1:0] s_ctrl_r,  s_ctrl_s;
  logic              in_ready_r, in_ready_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              accept_s, drain_s;
  logic [1:0]        kill_s;

  // An increment that would pass the top value pins the counter at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  assign accept_s = bus.in_valid & in_ready_r;
  assign drain_s  = m_valid_r & bus.out_ready;
  assign kill_s   = {1'b0, m_valid_r} + {1'b0, s_valid_r};

  // Next-state selection for main/skid entries, ready flag and flush counter.
  always_comb begin
    m_valid_s = m_valid_r;
    m_data_s  = m_data_r;
    m_ctrl_s  = m_ctrl_r;
    s_valid_s = s_valid_r;
    s_data_s  = s_data_r;
    s_ctrl_s  = s_ctrl_r;
    cnt_s     = cnt_r;
    if (Flush) begin
      // Held data is left in place; only valid and control are killed.
      m_valid_s = 1'b0;
      m_ctrl_s  = {CTRL_W{1'b0}};
      s_valid_s = 1'b0;
      s_ctrl_s  = {CTRL_W{1'b0}};
      cnt_s     = sat_add(cnt_r, kill_s);
    end else if (drain_s && s_valid_r) begin
      m_valid_s = 1'b1;
      m_data_s  = s_data_r;
      m_ctrl_s  = s_ctrl_r;
      s_valid_s = 1'b0;
    end else if (drain_s) begin
      if (accept_s) begin
        m_data_s = bus.in_data;
        m_ctrl_s = bus.in_ctrl;
      end else begin
        m_valid_s = 1'b0;
        m_ctrl_s  = {CTRL_W{1'b0}};
      end
    end else if (!m_valid_r) begin
      if (accept_s) begin
        m_valid_s = 1'b1;
        m_data_s  = bus.in_data;
        m_ctrl_s  = bus.in_ctrl;
      end else begin
        m_ctrl_s = {CTRL_W{1'b0}};
      end
    end else if (accept_s) begin
      s_valid_s = 1'b1;
      s_data_s  = bus.in_data;
      s_ctrl_s  = bus.in_ctrl;
    end else begin
      m_valid_s = m_valid_r;
    end
    in_ready_s = !s_valid_s;
  end

  // State registers, updated on the falling edge like the original pipeline register.
  always_ff @(negedge Clk or posedge Clr) begin
    if (Clr) begin
      m_valid_r  <= 1'b0;
      m_data_r   <= {DATA_W{1'b0}};
      m_ctrl_r   <= {CTRL_W{1'b0}};
      s_valid_r  <= 1'b0;
      s_data_r   <= {DATA_W{1'b0}};
      s_ctrl_r   <= {CTRL_W{1'b0}};
      in_ready_r <= 1'b1;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      m_valid_r  <= m_valid_s;
      m_data_r   <= m_data_s;
      m_ctrl_r   <= m_ctrl_s;
      s_valid_r  <= s_valid_s;
      s_data_r   <= s_data_s;
      s_ctrl_r   <= s_ctrl_s;
      in_ready_r <= in_ready_s;
      cnt_r      <= cnt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = m_valid_r;
  assign bus.out_data  = m_data_r;
  assign bus.out_ctrl  = m_ctrl_r;
  assign flush_cnt     = cnt_r;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: directed scenarios plus random traffic against a queue
// model of the stage; a second instance with a 2-bit counter checks saturation.
module tb_pipe_stage_elastic;

  typedef struct packed {
    logic [95:0] d;
    logic [4:0]  c;
  } beat_t;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       Flush = 1'b0;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_vec  = 0;
  int n_miss = 0;

  beat_t       q[$];
  int          m_cnt8 = 0;
  int          m_cnt2 = 0;

  pipe_stage_elastic_if #(.DATA_W(96), .CTRL_W(5)) bus_a ();
  pipe_stage_elastic_if #(.DATA_W(96), .CTRL_W(5)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_ctrl   = bus_a.in_ctrl;
  assign bus_b.out_ready = bus_a.out_ready;

  pipe_stage_elastic #(.DATA_W(96), .CTRL_W(5), .CNT_W(8)) dut_a (
    .Clk(Clk), .Clr(Clr), .Flush(Flush), .bus(bus_a), .flush_cnt(cnt_a)
  );

  pipe_stage_elastic #(.DATA_W(96), .CTRL_W(5), .CNT_W(2)) dut_b (
    .Clk(Clk), .Clr(Clr), .Flush(Flush), .bus(bus_b), .flush_cnt(cnt_b)
  );

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  // Stage as a FIFO of at most two beats; ready means room for one more.
  task automatic model_edge();
    bit rdy;
    bit drain;
    bit acc;
    rdy = (q.size() < 2);
    if (Flush) begin
      m_cnt8 = (m_cnt8 + q.size() > 255) ? 255 : m_cnt8 + q.size();
      m_cnt2 = (m_cnt2 + q.size() > 3) ? 3 : m_cnt2 + q.size();
      q.delete();
    end else begin
      drain = (q.size() > 0) && bus_a.out_ready;
      acc   = bus_a.in_valid && rdy;
      if (drain) void'(q.pop_front());
      if (acc) q.push_back({bus_a.in_data, bus_a.in_ctrl});
    end
  endtask

  task automatic check_all();
    chk("out_valid", 128'(bus_a.out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(bus_a.in_ready), 128'(q.size() < 2));
    chk("out_ctrl", 128'(bus_a.out_ctrl), (q.size() > 0) ? 128'(q[0].c) : 128'(0));
    if (q.size() > 0) chk("out_data", 128'(bus_a.out_data), 128'(q[0].d));
    chk("flush_cnt", 128'(cnt_a), 128'(m_cnt8));
    chk("flush_cnt_sat", 128'(cnt_b), 128'(m_cnt2));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 128'(bus_a.out_valid), 128'(0));
    chk({tag, "_ctrl"}, 128'(bus_a.out_ctrl), 128'(0));
    chk({tag, "_data"}, 128'(bus_a.out_data), 128'(0));
    chk({tag, "_ready"}, 128'(bus_a.in_ready), 128'(1));
    chk({tag, "_cnt"}, 128'(cnt_a), 128'(0));
    chk({tag, "_cnt_sat"}, 128'(cnt_b), 128'(0));
  endtask

  task automatic tick();
    @(negedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [95:0] d, input logic [4:0] c,
                       input logic r, input logic f);
    bus_a.in_valid  = v;
    bus_a.in_data   = d;
    bus_a.in_ctrl   = c;
    bus_a.out_ready = r;
    Flush           = f;
  endtask

  initial begin
    logic [95:0] rd;
    drive(1'b0, 96'h0, 5'b00000, 1'b0, 1'b0);
    #1 Clr = 1'b1;
    #1 check_reset("reset");
    model_reset();
    @(posedge Clk) Clr = 1'b0;

    // Streaming with the sink always ready.
    drive(1'b1, 96'h11, 5'b10011, 1'b1, 1'b0); tick();
    chk("stream_d0", 128'(bus_a.out_data), 128'h11);
    chk("stream_c0", 128'(bus_a.out_ctrl), 128'(5'b10011));
    drive(1'b1, 96'h22, 5'b10011, 1'b1, 1'b0); tick();
    chk("stream_d1", 128'(bus_a.out_data), 128'h22);
    drive(1'b1, 96'h33, 5'b10011, 1'b1, 1'b0); tick();
    chk("stream_d2", 128'(bus_a.out_data), 128'h33);
    chk("stream_rdy", 128'(bus_a.in_ready), 128'(1));
    drive(1'b0, 96'h0, 5'b00000, 1'b1, 1'b0); tick();
    chk("stream_end", 128'(bus_a.out_valid), 128'(0));

    // Stall fills the skid entry, then drains in order without a gap.
    drive(1'b1, 96'hA1, 5'b00101, 1'b0, 1'b0); tick();
    drive(1'b1, 96'hA2, 5'b00110, 1'b0, 1'b0); tick();
    chk("skid_head", 128'(bus_a.out_data), 128'hA1);
    chk("skid_full", 128'(bus_a.in_ready), 128'(0));
    drive(1'b1, 96'hA3, 5'b00111, 1'b0, 1'b0); tick();
    tick();
    chk("skid_hold", 128'(bus_a.out_data), 128'hA1);
    drive(1'b1, 96'hA3, 5'b00111, 1'b1, 1'b0); tick();
    chk("skid_d1", 128'(bus_a.out_data), 128'hA2);
    tick();
    chk("skid_d2", 128'(bus_a.out_data), 128'hA3);
    drive(1'b0, 96'h0, 5'b00000, 1'b1, 1'b0); tick();
    chk("skid_empty", 128'(bus_a.out_valid), 128'(0));

    // Flush with both entries occupied and a beat on the input.
    drive(1'b1, 96'hB1, 5'b11111, 1'b0, 1'b0); tick();
    drive(1'b1, 96'hB2, 5'b11111, 1'b0, 1'b0); tick();
    drive(1'b1, 96'hB3, 5'b11111, 1'b1, 1'b1); tick();
    chk("flush_valid", 128'(bus_a.out_valid), 128'(0));
    chk("flush_ctrl", 128'(bus_a.out_ctrl), 128'(0));
    chk("flush_ready", 128'(bus_a.in_ready), 128'(1));
    chk("flush_cnt2", 128'(cnt_a), 128'(2));
    drive(1'b0, 96'h0, 5'b00000, 1'b1, 1'b0); tick();
    chk("flush_b3_gone", 128'(bus_a.out_valid), 128'(0));

    // Flush of an empty stage, then normal flow.
    drive(1'b0, 96'h0, 5'b00000, 1'b0, 1'b1); tick();
    chk("flush_empty", 128'(cnt_a), 128'(2));
    drive(1'b1, 96'hC1, 5'b01001, 1'b1, 1'b0); tick();
    chk("after_flush", 128'(bus_a.out_data), 128'hC1);
    drive(1'b0, 96'h0, 5'b00000, 1'b1, 1'b0); tick();

    // Repeated double flushes drive the 2-bit counter into saturation.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 96'hE1, 5'b00011, 1'b0, 1'b0); tick();
      drive(1'b1, 96'hE2, 5'b00011, 1'b0, 1'b0); tick();
      drive(1'b0, 96'h0, 5'b00000, 1'b0, 1'b1); tick();
      chk("sat_cnt", 128'(cnt_b), 128'(3));
      chk("wide_cnt", 128'(cnt_a), 128'(4 + 2 * k));
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(0, 3) != 0), rd, 5'($urandom()),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end

    // Asynchronous reset while both entries are held.
    drive(1'b0, 96'h0, 5'b00000, 1'b0, 1'b1); tick();
    drive(1'b1, 96'hF1, 5'b10001, 1'b0, 1'b0); tick();
    drive(1'b1, 96'hF2, 5'b10001, 1'b0, 1'b0); tick();
    chk("pre_rst_full", 128'(bus_a.in_ready), 128'(0));
    drive(1'b0, 96'h0, 5'b00000, 1'b0, 1'b0);
    #2 Clr = 1'b1;
    #1 check_reset("async_rst");
    model_reset();
    @(posedge Clk) Clr = 1'b0;
    drive(1'b1, 96'hD1, 5'b10100, 1'b1, 1'b0); tick();
    chk("post_rst_d", 128'(bus_a.out_data), 128'hD1);
    chk("post_rst_c", 128'(bus_a.out_ctrl), 128'(5'b10100));
    drive(1'b0, 96'h0, 5'b00000, 1'b1, 1'b0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX/MEM-style pipeline register: one generic stage register for any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready back-pressure with a 2-entry skid buffer, so stalls never drop or duplicate a beat.
- Adds a synchronous flush that kills control bits, plus a saturating flushed-beat counter for performance debug.

Parameters:
- DATA_W, 96: width of payload fields passed unchanged through the stage (targets, bus values, ALU result, Rw, flags).
- CTRL_W, 5: width of control fields forced to 0 on flush or bubble (RegWr, MemtoReg, MemWr, Branch, Jump).
- CNT_W, 8: width of the flushed-beat counter.

Ports:
- Clk, in, 1: clock; all state updates on the negedge, matching the pipeline register convention.
- Clr, in, 1: asynchronous, active-high reset.
- Flush, in, 1: synchronous kill of all held beats (branch/jump taken).
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: stage can accept a beat; registered, no combinational path from out_ready.
- in_data, in, DATA_W: upstream payload.
- in_ctrl, in, CTRL_W: upstream control.
- out_valid, out, 1: downstream beat present.
- out_ready, in, 1: downstream accepts.
- out_data, out, DATA_W: payload to next stage.
- out_ctrl, out, CTRL_W: control to next stage; always 0 when out_valid=0.
- flush_cnt, out, CNT_W: number of valid beats killed by Flush; saturates.

Behaviour:
- Storage: main entry (M: valid, data, ctrl) drives the outputs; skid entry (S) holds a beat that arrived while M stalled.
- Reset (Clr=1, async): M.valid=S.valid=0; out_valid=0; out_ctrl=0; out_data=0; in_ready=1; flush_cnt=0. Clr held high overrides every other input. Release takes effect on the next negedge.
- Handshake: accept = in_valid & in_ready; drain = out_valid & out_ready. Both sampled on the negedge.
- in_ready = !S.valid, updated at the edge.
- Zero-latency behaviour is not provided: a beat accepted at edge n appears on the outputs after edge n (1-cycle latency).
- Normal update, Flush=0, evaluated per edge in this order:
  - drain & S.valid: M <= S; S.valid <= 0; a simultaneous accept is impossible, since in_ready=0.
  - drain & !S.valid: M <= the accepted beat if accept, else M.valid <= 0.
  - !drain & !M.valid: M <= the accepted beat if accept.
  - !drain & M.valid & accept: S <= the accepted beat; in_ready becomes 0.
  - Otherwise: hold.
- Flush=1, Clr=0:
  - M.valid <= 0, S.valid <= 0, out_ctrl <= 0.
  - out_data retains its old value (don't-care).
  - A beat presented with in_valid in the flush cycle is discarded, and in_ready <= 1.
  - flush_cnt increments by M.valid + S.valid (0, 1 or 2).
  - An out_ready=1 in the flush cycle is ignored: a beat that was valid is counted as flushed, not delivered.
- Counter: flush_cnt saturates at 2^CNT_W-1 and never wraps. An increment of 2 at max-1 yields max.
- Bubble: whenever M.valid=0, out_ctrl=0, so an unqualified downstream stage still sees no RegWr or MemWr.
- Ordering: beats leave in acceptance order; no beat is duplicated or lost except by Flush.
- Mid-operation reset: Clr asserted at any phase clears state immediately, without waiting for an edge. Pending beats are lost and not counted.

Test Plan:
- Reset then stream with out_ready=1: send in_data=0x11, 0x22, 0x33 with in_ctrl=5'b10011 on consecutive edges → each appears one edge later with ctrl 5'b10011; in_ready stays 1; flush_cnt=0.
- Stall and skid: hold out_ready=0, send 0xA1 then 0xA2 → out_data=0xA1; in_ready=0 after the second accept; 0xA3 is held off. Raise out_ready → 0xA1, 0xA2, 0xA3 are delivered in order with no gap after the skid drains.
- Flush with both entries full: M=0xB1, S=0xB2, in_valid=1 with 0xB3, Flush=1 → next edge: out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=2; 0xB3 is never output.
- Flush with empty stage: Flush=1, no held beats → flush_cnt unchanged; a following beat 0xC1 flows normally.
- Saturation with CNT_W=2: perform double flushes → flush_cnt goes 0, 2, then 3, and stays 3 on further flushes.
- Async reset mid-stall: M and S full, assert Clr between edges → out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=0 before the next edge. After release, a new beat 0xD1 passes with 1-cycle latency.
